ram_arb_2to1: RTL and testbench
===============================

# ram_arb_2to1

Two-host arbiter that sits directly upstream of one port of the dual-port 32-bit RAM and lets two requestors share it, e.g. core data port and debug/DMA. Grants at most one request per cycle, forwards it to the RAM port, and routes the one-cycle-later RAM response back to the owning host. Requests outside the RAM's address window are granted but never forwarded; they get an error response instead.

## Interface
- `AddrBase`, default 32'h0010_0000: byte base address of the RAM window.
- `Depth`, default 128: RAM depth in 32-bit words; window is [AddrBase, AddrBase + 4*Depth).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous active-low reset.
- `hN_req_i`  in  1  request from host N (N = 0, 1).
- `hN_we_i`  in  1  write enable, host N.
- `hN_be_i`  in  4  byte enables, host N.
- `hN_addr_i`  in  32  byte address, host N.
- `hN_wdata_i`  in  32  write data, host N.
- `hN_gnt_o`  out  1  grant to host N, combinational, same cycle as request.
- `hN_rvalid_o`  out  1  response valid to host N, for reads and writes.
- `hN_rdata_o`  out  32  read data to host N.
- `hN_err_o`  out  1  error flag, qualified by `hN_rvalid_o`.
- `ram_req_o`, `ram_we_o`  out  1  request and write enable to the RAM port.
- `ram_be_o`  out  4  byte enables to the RAM port.
- `ram_addr_o`, `ram_wdata_o`  out  32  byte address and write data to the RAM port.
- `ram_rvalid_i`  in  1  response valid from the RAM port.
- `ram_rdata_i`  in  32  read data from the RAM port.

## Operation
- **Arbitration.** Each cycle, pick at most one host with req=1.
  - Only one host requesting: that host wins.
  - Both requesting: the host selected by priority pointer `prio_q` wins (see Configuration).
  - Grant the winner. The loser sees gnt=0 and must hold its request stable.
- **Range check.**
  - In range: `addr - AddrBase < 4*Depth`, unsigned 32-bit subtraction. This handles wrap-around: addresses below `AddrBase` wrap to large values and fail the check.
  - In-range winner: drive `ram_req_o`=1 and pass we/be/addr/wdata through unchanged. The RAM ignores `addr[1:0]`.
  - Out-of-range winner: still granted, but `ram_req_o`=0.
  - No winner: `ram_req_o`=0 and all `ram_*` outputs are 0.
- **Pending register.** Fields `pend_vld_q`, `pend_host_q`, `pend_err_q`. Loaded every cycle:
  - `pend_vld_q` = any grant.
  - `pend_host_q` = winning host.
  - `pend_err_q` = out of range.
- **Response routing.** When `pend_vld_q`=1, only the host `pend_host_q` sees `rvalid`=1.
  - `pend_err_q`=0: `rdata` = `ram_rdata_i`, `err`=0.
  - `pend_err_q`=1: `rdata`=0, `err`=1.
  - The non-owning host always sees `rvalid`=0, `rdata`=0, `err`=0.
- **Protocol check.** `ram_rvalid_i` must equal `pend_vld_q & ~pend_err_q`. Any mismatch is an assertion failure; routing still uses the pending register.

## Timing
- **Reset values.** All `hN_*_o` and `ram_*_o` outputs are 0. `pend_vld_q`=0. `prio_q` points to host 0.
- **Grant.** Same cycle as request, combinational from `req`/`addr`/`prio_q`. No registered path from req to gnt.
- **Response latency.** Exactly 1 cycle after grant, for in-range and out-of-range accesses alike.
- **Throughput.** One grant per cycle, with no bubbles. Back-to-back grants to the same or alternating hosts are allowed. A response and a new grant can occur in the same cycle.
- **Simultaneous requests.** Exactly one gnt is asserted; the other host retries on the following cycle.
- **Reset mid-operation.** An outstanding response is discarded and no rvalid is issued after reset deasserts.

## Configuration
- Macro `RAM_ARB_RR_EN`.
  - **Defined:** round-robin. After any contested grant, `prio_q` moves to the non-winning host. Uncontested grants do not change `prio_q`.
  - **Undefined:** fixed priority. Host 0 always wins contention, and `prio_q` is a constant 0 with no flop.

## Test plan
- **Single read.** Host 0 reads in-range address AddrBase+0x10, RAM returns 32'hDEADBEEF next cycle → `h0_gnt_o`=1 in the request cycle, `ram_addr_o`=AddrBase+0x10, next cycle `h0_rvalid_o`=1, `h0_rdata_o`=DEADBEEF, `h0_err_o`=0, `h1_rvalid_o`=0.
- **Contention, RR enabled.** Both hosts request every cycle for 4 cycles → grants alternate h0, h1, h0, h1; each rvalid goes to the matching host one cycle later.
- **Contention, RR disabled.** Same stimulus → h0 is granted all 4 cycles, h1 never; h1 is granted on the first cycle h0 drops req.
- **Out-of-range.** Host 1 writes AddrBase+4*Depth, then AddrBase-4 → both granted with `ram_req_o`=0; next cycle `h1_rvalid_o`=1, `h1_err_o`=1, `h1_rdata_o`=0.
- **Write then read.** Host 0 writes be=4'b0011, wdata=32'h12345678, immediately followed by a read of the same address → `ram_be_o`=0011 in cycle 0; two consecutive h0 rvalids in cycles 1 and 2 with err=0.
- **Reset mid-operation.** Assert `rst_ni`=0 in the cycle after a grant → all outputs go to 0 immediately; after release no stray rvalid appears and the first contested grant goes to host 0.

Source files
------------

// File: rtl/ram_arb_2to1_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_arb_2to1_if: host and RAM-port signals of the 2:1 arbiter.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface ram_arb_2to1_if;
   logic        h0_req_i;
   logic        h0_we_i;
   logic [3:0]  h0_be_i;
   logic [31:0] h0_addr_i;
   logic [31:0] h0_wdata_i;
   logic        h0_gnt_o;
   logic        h0_rvalid_o;
   logic [31:0] h0_rdata_o;
   logic        h0_err_o;

   logic        h1_req_i;
   logic        h1_we_i;
   logic [3:0]  h1_be_i;
   logic [31:0] h1_addr_i;
   logic [31:0] h1_wdata_i;
   logic        h1_gnt_o;
   logic        h1_rvalid_o;
   logic [31:0] h1_rdata_o;
   logic        h1_err_o;

   logic        ram_req_o;
   logic        ram_we_o;
   logic [3:0]  ram_be_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic        ram_rvalid_i;
   logic [31:0] ram_rdata_i;

   modport slave (
      input  h0_req_i, h0_we_i, h0_be_i, h0_addr_i, h0_wdata_i,
      output h0_gnt_o, h0_rvalid_o, h0_rdata_o, h0_err_o,
      input  h1_req_i, h1_we_i, h1_be_i, h1_addr_i, h1_wdata_i,
      output h1_gnt_o, h1_rvalid_o, h1_rdata_o, h1_err_o,
      output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
      input  ram_rvalid_i, ram_rdata_i
   );

   modport master (
      output h0_req_i, h0_we_i, h0_be_i, h0_addr_i, h0_wdata_i,
      input  h0_gnt_o, h0_rvalid_o, h0_rdata_o, h0_err_o,
      output h1_req_i, h1_we_i, h1_be_i, h1_addr_i, h1_wdata_i,
      input  h1_gnt_o, h1_rvalid_o, h1_rdata_o, h1_err_o,
      input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
      output ram_rvalid_i, ram_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/ram_arb_2to1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_arb_2to1: two-host arbiter in front of one 32-bit RAM port;  |
// | out-of-window accesses get an error response. RAM_ARB_RR_EN      |
// | selects round-robin, otherwise host 0 has fixed priority.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ram_arb_2to1 #(
   parameter logic [31:0] AddrBase = 32'h0010_0000,
   parameter int unsigned Depth    = 128
) (
   input  wire logic     clk_i,
   input  wire logic     rst_ni,
   ram_arb_2to1_if.slave bus
);
   localparam logic [31:0] WIN_BYTES = 32'(4 * Depth);

   logic        h0_win, h1_win, any_gnt, in_range, fwd;
   logic        sel_we;
   logic [3:0]  sel_be;
   logic [31:0] sel_addr, sel_wdata, off;
   logic        pend_vld_d, pend_vld_q;
   logic        pend_host_d, pend_host_q;
   logic        pend_err_d, pend_err_q;
   logic        prio_q;

   // Grants are gated by reset so every output reads 0 while rst_ni is low.
   always_comb begin
      h0_win = 1'b0;
      h1_win = 1'b0;
      if (rst_ni) begin
         if (bus.h0_req_i && bus.h1_req_i) begin
            h0_win = ~prio_q;
            h1_win = prio_q;
         end else begin
            h0_win = bus.h0_req_i;
            h1_win = bus.h1_req_i;
         end
      end
      any_gnt     = h0_win | h1_win;
      sel_we      = h1_win ? bus.h1_we_i    : bus.h0_we_i;
      sel_be      = h1_win ? bus.h1_be_i    : bus.h0_be_i;
      sel_addr    = h1_win ? bus.h1_addr_i  : bus.h0_addr_i;
      sel_wdata   = h1_win ? bus.h1_wdata_i : bus.h0_wdata_i;
      off         = sel_addr - AddrBase;
      in_range    = off < WIN_BYTES;
      fwd         = any_gnt & in_range;
      pend_vld_d  = any_gnt;
      pend_host_d = h1_win;
      pend_err_d  = any_gnt & ~in_range;
   end

`ifdef RAM_ARB_RR_EN
   logic prio_d;

   // After a contested grant the loser gets priority next time.
   always_comb begin
      prio_d = prio_q;
      if (bus.h0_req_i && bus.h1_req_i && any_gnt)
         prio_d = h0_win;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prio_q <= 1'b0;
      else         prio_q <= prio_d;
   end
`else
   assign prio_q = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_vld_q  <= 1'b0;
         pend_host_q <= 1'b0;
         pend_err_q  <= 1'b0;
      end else begin
         pend_vld_q  <= pend_vld_d;
         pend_host_q <= pend_host_d;
         pend_err_q  <= pend_err_d;
      end
   end

   assign bus.h0_gnt_o    = h0_win;
   assign bus.h1_gnt_o    = h1_win;
   assign bus.ram_req_o   = fwd;
   assign bus.ram_we_o    = fwd & sel_we;
   assign bus.ram_be_o    = fwd ? sel_be    : 4'b0;
   assign bus.ram_addr_o  = fwd ? sel_addr  : 32'b0;
   assign bus.ram_wdata_o = fwd ? sel_wdata : 32'b0;

   assign bus.h0_rvalid_o = pend_vld_q & ~pend_host_q;
   assign bus.h1_rvalid_o = pend_vld_q &  pend_host_q;
   assign bus.h0_rdata_o  = (bus.h0_rvalid_o & ~pend_err_q) ? bus.ram_rdata_i : 32'b0;
   assign bus.h1_rdata_o  = (bus.h1_rvalid_o & ~pend_err_q) ? bus.ram_rdata_i : 32'b0;
   assign bus.h0_err_o    = bus.h0_rvalid_o & pend_err_q;
   assign bus.h1_err_o    = bus.h1_rvalid_o & pend_err_q;

   // The RAM must answer exactly the forwarded accesses, one cycle later.
   ram_rvalid_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.ram_rvalid_i == (pend_vld_q & ~pend_err_q));

endmodule
`default_nettype wire

// File: tb/tb_ram_arb_2to1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ram_arb_2to1: directed bench with a response scoreboard and a |
// | small RAM model behind the arbiter.                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ram_arb_2to1;
   localparam logic [31:0] BASE = 32'h0010_0000;

   typedef struct {
      int          due;
      bit          host;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];
   exp_t        mon_e;
   logic [31:0] mem [128];

   ram_arb_2to1_if bus();

   ram_arb_2to1 dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: one-cycle response, byte-enabled writes, reads of 0 on writes.
   always @(posedge clk or negedge rst_n) begin
      logic [6:0] idx;
      if (!rst_n) begin
         bus.ram_rvalid_i <= 1'b0;
         bus.ram_rdata_i  <= 32'b0;
         for (int i = 0; i < 128; i++) mem[i] <= 32'b0;
         mem[4]   <= 32'hDEAD_BEEF;
         mem[8]   <= 32'hAABB_CCDD;
         mem[127] <= 32'h0BAD_F00D;
      end else begin
         bus.ram_rvalid_i <= bus.ram_req_o;
         bus.ram_rdata_i  <= 32'b0;
         if (bus.ram_req_o) begin
            idx = 7'((bus.ram_addr_o - BASE) >> 2);
            if (bus.ram_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (bus.ram_be_o[b]) mem[idx][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
            end else begin
               bus.ram_rdata_i <= mem[idx];
            end
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expectation due now.
   always @(negedge clk) begin
      if (bus.h0_rvalid_o || bus.h1_rvalid_o) begin
         if (q.size() == 0 || q[0].due != cyc) begin
            checks++;
            errors++;
            $display("FAIL stray_rvalid got rvalid0=%b rvalid1=%b expected none at cycle %0d",
                     bus.h0_rvalid_o, bus.h1_rvalid_o, cyc);
         end else begin
            mon_e = q.pop_front();
            cmp("rsp_rvalid0", 32'(bus.h0_rvalid_o), 32'(!mon_e.host));
            cmp("rsp_rvalid1", 32'(bus.h1_rvalid_o), 32'(mon_e.host));
            cmp("rsp_rdata", mon_e.host ? bus.h1_rdata_o : bus.h0_rdata_o, mon_e.rdata);
            cmp("rsp_err", 32'(mon_e.host ? bus.h1_err_o : bus.h0_err_o), 32'(mon_e.err));
            cmp("rsp_other_rdata", mon_e.host ? bus.h0_rdata_o : bus.h1_rdata_o, 32'b0);
            cmp("rsp_other_err", 32'(mon_e.host ? bus.h0_err_o : bus.h1_err_o), 32'b0);
         end
      end else if (q.size() != 0 && q[0].due == cyc) begin
         mon_e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_rvalid got 0 expected 1 for host %0d at cycle %0d", mon_e.host, cyc);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic set_h(input bit h, input bit req, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (h) begin
         bus.h1_req_i = req; bus.h1_we_i = we; bus.h1_be_i = be;
         bus.h1_addr_i = addr; bus.h1_wdata_i = wd;
      end else begin
         bus.h0_req_i = req; bus.h0_we_i = we; bus.h0_be_i = be;
         bus.h0_addr_i = addr; bus.h0_wdata_i = wd;
      end
   endtask

   task automatic clr();
      set_h(0, 0, 0, 4'b0, 32'b0, 32'b0);
      set_h(1, 0, 0, 4'b0, 32'b0, 32'b0);
   endtask

   // Checks the grant-cycle outputs and queues the response due next cycle.
   task automatic chk(input string nm, input bit eg0, input bit eg1, input bit erq,
                      input logic [31:0] er, input bit ee);
      @(negedge clk);
      cmp({nm, "_gnt0"}, 32'(bus.h0_gnt_o), 32'(eg0));
      cmp({nm, "_gnt1"}, 32'(bus.h1_gnt_o), 32'(eg1));
      cmp({nm, "_ram_req"}, 32'(bus.ram_req_o), 32'(erq));
      if (erq) begin
         cmp({nm, "_ram_addr"},  bus.ram_addr_o,  eg1 ? bus.h1_addr_i  : bus.h0_addr_i);
         cmp({nm, "_ram_we"},    32'(bus.ram_we_o), 32'(eg1 ? bus.h1_we_i : bus.h0_we_i));
         cmp({nm, "_ram_be"},    32'(bus.ram_be_o), 32'(eg1 ? bus.h1_be_i : bus.h0_be_i));
         cmp({nm, "_ram_wdata"}, bus.ram_wdata_o, eg1 ? bus.h1_wdata_i : bus.h0_wdata_i);
      end else begin
         cmp({nm, "_ram_addr0"}, bus.ram_addr_o, 32'b0);
         cmp({nm, "_ram_be0"},   32'(bus.ram_be_o), 32'b0);
      end
      if (eg0 || eg1) q.push_back('{cyc + 1, eg1, er, ee});
   endtask

   initial begin
      bit w1;
      rst_n = 1'b0;
      bus.ram_rvalid_i = 1'b0;
      bus.ram_rdata_i  = 32'b0;
      set_h(0, 1, 0, 4'hF, BASE + 32'h10, 32'b0);
      set_h(1, 1, 0, 4'hF, BASE + 32'h20, 32'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 0, 0, 0, 32'b0, 0);
      cmp("reset_rvalid0", 32'(bus.h0_rvalid_o), 32'b0);
      cmp("reset_rvalid1", 32'(bus.h1_rvalid_o), 32'b0);

      nxt(); rst_n = 1'b1; clr();
      chk("idle0", 0, 0, 0, 32'b0, 0);

      // Single in-range read by host 0.
      nxt(); set_h(0, 1, 0, 4'hF, BASE + 32'h10, 32'b0);
      chk("rd0", 1, 0, 1, 32'hDEAD_BEEF, 0);
      nxt(); clr();
      chk("idle1", 0, 0, 0, 32'b0, 0);

      // Four contested cycles, then host 0 drops out.
      for (int i = 0; i < 4; i++) begin
         nxt();
         set_h(0, 1, 0, 4'hF, BASE + 32'h10, 32'b0);
         set_h(1, 1, 0, 4'hF, BASE + 32'h20, 32'b0);
`ifdef RAM_ARB_RR_EN
         w1 = (i % 2) == 1;
`else
         w1 = 1'b0;
`endif
         chk("cont", !w1, w1, 1, w1 ? 32'hAABB_CCDD : 32'hDEAD_BEEF, 0);
      end
      nxt(); set_h(0, 0, 0, 4'h0, 32'b0, 32'b0);
      chk("h1_after_drop", 0, 1, 1, 32'hAABB_CCDD, 0);

      // Window boundaries.
      nxt(); set_h(1, 1, 1, 4'hF, BASE + 32'h200, 32'h1111_1111);
      chk("oor_hi", 0, 1, 0, 32'b0, 1);
      nxt(); set_h(1, 1, 1, 4'hF, BASE - 32'd4, 32'h2222_2222);
      chk("oor_lo", 0, 1, 0, 32'b0, 1);
      nxt(); set_h(1, 1, 0, 4'hF, BASE + 32'h1FC, 32'b0);
      chk("last_word", 0, 1, 1, 32'h0BAD_F00D, 0);

      // Partial write followed immediately by a read of the same word.
      nxt(); clr(); set_h(0, 1, 1, 4'b0011, BASE + 32'h20, 32'h1234_5678);
      chk("wr", 1, 0, 1, 32'b0, 0);
      nxt(); set_h(0, 1, 0, 4'hF, BASE + 32'h20, 32'b0);
      chk("rd_after_wr", 1, 0, 1, 32'hAABB_5678, 0);

      // Contested grant, then reset while its response is outstanding.
      nxt();
      set_h(0, 1, 0, 4'hF, BASE + 32'h10, 32'b0);
      set_h(1, 1, 0, 4'hF, BASE + 32'h20, 32'b0);
      chk("pre_rst", 1, 0, 1, 32'hDEAD_BEEF, 0);
      nxt(); rst_n = 1'b0; q.delete();
      chk("in_rst", 0, 0, 0, 32'b0, 0);
      cmp("in_rst_rvalid0", 32'(bus.h0_rvalid_o), 32'b0);
      cmp("in_rst_rvalid1", 32'(bus.h1_rvalid_o), 32'b0);
      nxt(); rst_n = 1'b1; clr();
      chk("post_rst", 0, 0, 0, 32'b0, 0);
      cmp("post_rst_rvalid0", 32'(bus.h0_rvalid_o), 32'b0);
      cmp("post_rst_rvalid1", 32'(bus.h1_rvalid_o), 32'b0);
      nxt();
      set_h(0, 1, 0, 4'hF, BASE + 32'h10, 32'b0);
      set_h(1, 1, 0, 4'hF, BASE + 32'h20, 32'b0);
      chk("rst_prio", 1, 0, 1, 32'hDEAD_BEEF, 0);
      nxt(); clr();
      chk("final_idle", 0, 0, 0, 32'b0, 0);
      nxt(); nxt();
      cmp("queue_empty", 32'(q.size()), 32'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
